// File: rtl/icache_pkg.sv
// Shared types, constants and address-field width helpers for the icache.
package icache_pkg;

  typedef enum logic [1:0] {StIdle, StFill, StRetry} state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam int unsigned OffW     = 2;

  function automatic int unsigned word_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned lines, input int unsigned line_words);
    return 32 - OffW - $clog2(lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with a Wishbone B4 classic line-fill port.
// Optional macro ICACHE_ERR_NOP_EN: a bus error fills the word with a NOP instead of retrying.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  output logic [31:0] INS,
  output logic        stall,
  input  logic        ACK,
  input  logic        ERR,
  input  logic        RTY,
  output logic        CYC,
  output logic        STB,
  output logic        WE,
  output logic [31:0] ADR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O
);

  localparam int unsigned WordW = word_w(LINE_WORDS);
  localparam int unsigned IdxW  = idx_w(LINES);
  localparam int unsigned TagW  = tag_w(LINES, LINE_WORDS);
  localparam int unsigned AddrW = IdxW + WordW;
  localparam logic [WordW-1:0] LastWord = WordW'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [31:0]       adr_q, adr_d;
  logic [WordW-1:0]  cnt_q, cnt_d;
  logic [LINES-1:0]  valid_q;
  logic [TagW-1:0]   tag_q  [LINES];
  logic [31:0]       data_q [LINES*LINE_WORDS];

  logic [WordW-1:0]  pc_word;
  logic [IdxW-1:0]   pc_idx, fill_idx;
  logic [TagW-1:0]   pc_tag, fill_tag;
  logic [AddrW-1:0]  rd_addr, wr_addr;
  logic              hit;
  logic              err_fill;
  logic              data_we, set_valid, clr_valid;
  logic [31:0]       wdata;
  logic              unused_pc;

  assign unused_pc = ^PC[OffW-1:0];

  assign pc_word  = PC[OffW +: WordW];
  assign pc_idx   = PC[OffW+WordW +: IdxW];
  assign pc_tag   = PC[31 -: TagW];
  // The fill target comes from the bus address, not PC, so it is immune to PC changes.
  assign fill_idx = adr_q[OffW+WordW +: IdxW];
  assign fill_tag = adr_q[31 -: TagW];
  assign rd_addr  = {pc_idx, pc_word};
  assign wr_addr  = {fill_idx, cnt_q};

  assign hit   = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign stall = !hit || (state_q != StIdle);
  assign INS   = hit ? data_q[rd_addr] : 32'h0;

  assign CYC   = (state_q == StFill);
  assign STB   = CYC;
  assign WE    = 1'b0;
  assign ADR   = adr_q;
  assign DAT_O = 32'h0;

`ifdef ICACHE_ERR_NOP_EN
  assign err_fill = ERR;
`else
  assign err_fill = 1'b0;
`endif

  assign wdata = ACK ? DAT_I : NOP_INSN;

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    cnt_d     = cnt_q;
    data_we   = 1'b0;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!hit) begin
          state_d   = StFill;
          adr_d     = {pc_tag, pc_idx, {WordW{1'b0}}, 2'b00};
          cnt_d     = '0;
          clr_valid = 1'b1;
        end
      end
      StFill: begin
        if (ACK || err_fill) begin
          data_we = 1'b1;
          if (cnt_q == LastWord) begin
            set_valid = 1'b1;
            state_d   = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
            adr_d = adr_q + 32'd4;
          end
        end else if (ERR || RTY) begin
          state_d = StRetry;
        end
      end
      StRetry: state_d = StFill;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      adr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      if (clr_valid) valid_q[pc_idx] <= 1'b0;
      if (set_valid) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Arrays carry no reset; valid_q alone decides whether their contents are used.
  always_ff @(posedge clk) begin
    if (!rst && data_we) data_q[wr_addr] <= wdata;
    if (!rst && set_valid) tag_q[fill_idx] <= fill_tag;
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache with a zero-wait Wishbone memory model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic [31:0] INS;
  logic        stall;
  logic        ACK, ERR, RTY;
  logic        CYC, STB, WE;
  logic [31:0] ADR;
  logic [31:0] DAT_I, DAT_O;

  int checks = 0;
  int errors = 0;

  // One-shot fault injection: fires once per increment of fault_id.
  int          fault_id    = 0;
  int          served_id   = 0;
  logic [31:0] fault_adr   = 32'h0;
  bit          fault_err   = 1'b0;
  logic        fault_act;

  always #5 clk = ~clk;

  icache #(.LINES(64), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .PC(PC), .INS(INS), .stall(stall),
    .ACK(ACK), .ERR(ERR), .RTY(RTY), .CYC(CYC), .STB(STB), .WE(WE),
    .ADR(ADR), .DAT_I(DAT_I), .DAT_O(DAT_O)
  );

  always_comb begin
    fault_act = CYC && STB && (ADR == fault_adr) && (fault_id != served_id);
    ACK   = CYC && STB && !fault_act;
    ERR   = fault_act && fault_err;
    RTY   = fault_act && !fault_err;
    DAT_I = 32'h1000 + ADR;
  end

  always @(posedge clk) if (fault_act) served_id <= fault_id;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc();
    int n = 0;
    while (!CYC && n < 5) begin
      tick();
      n++;
    end
    check("fill_start_cyc", {31'b0, CYC}, 32'h1);
  endtask

  // Expects an undisturbed fill of the line at base, then a hit on PC.
  task automatic expect_fill(input logic [31:0] base);
    wait_cyc();
    for (int i = 0; i < 4; i++) begin
      check("fill_adr", ADR, base + 32'(4 * i));
      check("fill_stall", {31'b0, stall}, 32'h1);
      tick();
    end
    check("fill_end_cyc", {31'b0, CYC}, 32'h0);
    check("fill_end_stall", {31'b0, stall}, 32'h0);
  endtask

  task automatic expect_hit(input logic [31:0] pc, input logic [31:0] ins);
    PC = pc;
    #1;
    check("hit_stall", {31'b0, stall}, 32'h0);
    check("hit_ins", INS, ins);
    check("hit_cyc", {31'b0, CYC}, 32'h0);
    tick();
    check("hit_cyc_after_edge", {31'b0, CYC}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    PC  = 32'h0;
    tick();
    tick();
    // Reset state
    check("rst_cyc", {31'b0, CYC}, 32'h0);
    check("rst_stb", {31'b0, STB}, 32'h0);
    check("rst_adr", ADR, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h1);
    check("we_tied", {31'b0, WE}, 32'h0);
    check("dat_o_tied", DAT_O, 32'h0);
    rst = 1'b0;

    // Cold start fill of line 0
    expect_fill(32'h0);
    check("cold_ins", INS, 32'h1000);

    // Sequential hits
    expect_hit(32'h4, 32'h1004);
    expect_hit(32'h8, 32'h1008);
    expect_hit(32'hC, 32'h100C);

    // Conflict miss on the same index
    PC = 32'h400;
    #1;
    check("conflict_stall", {31'b0, stall}, 32'h1);
    expect_fill(32'h400);
    check("conflict_ins", INS, 32'h1400);
    PC = 32'h0;
    #1;
    check("evicted_stall", {31'b0, stall}, 32'h1);
    expect_fill(32'h0);
    check("refill_ins", INS, 32'h1000);

    // RTY on the second word
    fault_adr = 32'h14;
    fault_err = 1'b0;
    fault_id++;
    PC = 32'h10;
    wait_cyc();
    check("rty_w0_adr", ADR, 32'h10);
    tick();
    check("rty_adr", ADR, 32'h14);
    check("rty_seen", {31'b0, RTY}, 32'h1);
    tick();
    check("rty_idle_cyc", {31'b0, CYC}, 32'h0);
    check("rty_idle_stb", {31'b0, STB}, 32'h0);
    check("rty_idle_stall", {31'b0, stall}, 32'h1);
    tick();
    check("rty_reissue_cyc", {31'b0, CYC}, 32'h1);
    check("rty_reissue_adr", ADR, 32'h14);
    tick();
    check("rty_w2_adr", ADR, 32'h18);
    tick();
    check("rty_w3_adr", ADR, 32'h1C);
    tick();
    check("rty_done_stall", {31'b0, stall}, 32'h0);
    check("rty_ins0", INS, 32'h1010);
    expect_hit(32'h14, 32'h1014);
    expect_hit(32'h1C, 32'h101C);

    // ERR on the third word
    fault_adr = 32'h28;
    fault_err = 1'b1;
    fault_id++;
    PC = 32'h20;
    wait_cyc();
    tick();
    tick();
    check("err_adr", ADR, 32'h28);
    check("err_seen", {31'b0, ERR}, 32'h1);
    tick();
`ifdef ICACHE_ERR_NOP_EN
    check("err_next_adr", ADR, 32'h2C);
    check("err_cyc_held", {31'b0, CYC}, 32'h1);
    tick();
    check("err_done_stall", {31'b0, stall}, 32'h0);
    expect_hit(32'h28, 32'h0000_0013);
`else
    check("err_idle_cyc", {31'b0, CYC}, 32'h0);
    tick();
    check("err_reissue_adr", ADR, 32'h28);
    check("err_reissue_cyc", {31'b0, CYC}, 32'h1);
    tick();
    check("err_w3_adr", ADR, 32'h2C);
    tick();
    check("err_done_stall", {31'b0, stall}, 32'h0);
    expect_hit(32'h28, 32'h1028);
`endif
    expect_hit(32'h2C, 32'h102C);

    // Reset during the third ACK of a fill
    PC = 32'h30;
    wait_cyc();
    tick();
    tick();
    check("rstfill_adr", ADR, 32'h38);
    check("rstfill_ack", {31'b0, ACK}, 32'h1);
    rst = 1'b1;
    tick();
    check("rstfill_cyc", {31'b0, CYC}, 32'h0);
    check("rstfill_adr0", ADR, 32'h0);
    rst = 1'b0;
    PC  = 32'h0;
    #1;
    check("rstfill_miss", {31'b0, stall}, 32'h1);
    expect_fill(32'h0);
    check("rstfill_ins", INS, 32'h1000);
    PC = 32'h30;
    #1;
    check("rstfill_line_invalid", {31'b0, stall}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
